keypad_scan_4x4: RTL and testbench



---
 rtl/keypad_scan_4x4_if.sv | 28 ++
 rtl/keypad_scan_4x4.sv | 222 ++++++++++++++++++++++
 tb/tb_keypad_scan_4x4.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_scan_4x4_if.sv
// keypad_scan_4x4_if: key-matrix lines and decoded key outputs of the 4x4 keypad scanner.
// The master side is the scanner; the slave side is the matrix/consumer.
interface keypad_scan_4x4_if;
    logic [3:0]  KEY_ROW;
    logic [3:0]  KEY_COL;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_down;
    logic [15:0] data;

    modport master (
        input  KEY_ROW,
        output KEY_COL,
        output key_code,
        output key_valid,
        output key_down,
        output data
    );

    modport slave (
        output KEY_ROW,
        input  KEY_COL,
        input  key_code,
        input  key_valid,
        input  key_down,
        input  data
    );
endinterface

// File: rtl/keypad_scan_4x4.sv
// keypad_scan_4x4: scans a 4x4 active-low key matrix column by column,
// debounces whole-matrix frames and emits hex key codes with a one-cycle
// valid strobe, plus a 16-bit history of the last four codes.
// Optional auto-repeat while a single key is held: define KEYPAD_AUTOREPEAT_EN.
module keypad_scan_4x4 #(
    parameter int SCAN_DIV      = 16,
    parameter int DEBOUNCE_CNT  = 3,
    parameter int REPEAT_FRAMES = 32
) (
    input  logic              CLK,
    input  logic              RSTN,
    keypad_scan_4x4_if.master kp
);
    localparam int CNT_W   = $clog2(SCAN_DIV);
    localparam int MATCH_W = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [CNT_W-1:0]   DWELL_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [MATCH_W-1:0] MATCH_MAX  = MATCH_W'(DEBOUNCE_CNT);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HELD = 1'b1;

    // Reject parameter values the scan and debounce logic cannot support
    if (SCAN_DIV < 4 || DEBOUNCE_CNT < 1 || REPEAT_FRAMES < 1) begin : g_param_check
        $error("keypad_scan_4x4: parameter out of range");
    end

    logic [3:0]         row_meta_q, row_meta_d;
    logic [3:0]         row_sync_q, row_sync_d;
    logic [CNT_W-1:0]   scan_cnt_q, scan_cnt_d;
    logic [1:0]         col_q, col_d;
    logic [15:0]        raw_q, raw_d;
    logic [15:0]        prev_q, prev_d;
    logic [15:0]        stable_q, stable_d;
    logic [MATCH_W-1:0] match_q, match_d;
    logic               upd_q, upd_d;
    logic [0:0]         state_q, state_d;
    logic [3:0]         key_code_q, key_code_d;
    logic               key_valid_q, key_valid_d;
    logic               key_down_q, key_down_d;
    logic [15:0]        data_q, data_d;

    logic               dwell_end;
    logic               frame_done;
    logic [15:0]        frame_raw;
    logic               any_key;
    logic               one_key;
    logic [3:0]         key_idx;
    logic               fire;
    logic               repeat_due;

    assign dwell_end  = (scan_cnt_q == DWELL_LAST);
    assign frame_done = dwell_end && (col_q == 2'd3);

    // Row returns are asynchronous to CLK, so pass them through two flops
    always_comb begin
        row_meta_d = kp.KEY_ROW;
        row_sync_d = row_meta_q;
    end

    // Dwell counter; the column advances right after the last dwell cycle
    always_comb begin
        scan_cnt_d = scan_cnt_q + 1'b1;
        col_d      = col_q;
        if (dwell_end) begin
            scan_cnt_d = '0;
            col_d      = col_q + 2'd1;
        end
    end

    // Merge the current column's inverted rows into the frame being assembled
    always_comb begin
        frame_raw = raw_q;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (col_q == 2'(c)) begin
                    frame_raw[r*4+c] = ~row_sync_q[r];
                end
            end
        end
        raw_d = dwell_end ? frame_raw : raw_q;
    end

    // Whole-frame debounce: enough identical frames in a row update the stable frame
    always_comb begin
        match_d  = match_q;
        prev_d   = prev_q;
        stable_d = stable_q;
        upd_d    = 1'b0;
        if (frame_done) begin
            prev_d = frame_raw;
            if (frame_raw != prev_q) begin
                match_d = MATCH_W'(1);
            end else if (match_q < MATCH_MAX) begin
                match_d = match_q + 1'b1;
            end
            if (match_d >= MATCH_MAX) begin
                stable_d = frame_raw;
                upd_d    = 1'b1;
            end
        end
    end

    // Classify the stable frame: any key, exactly one key, and its index
    always_comb begin
        any_key = |stable_q;
        one_key = any_key && ((stable_q & (stable_q - 16'd1)) == 16'd0);
        key_idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (stable_q[i]) begin
                key_idx = 4'(i);
            end
        end
    end

    // Press/release FSM: accept a lone key from idle, then wait for full release
    always_comb begin
        state_d = state_q;
        fire    = 1'b0;
        if (upd_q) begin
            case (state_q)
                ST_IDLE: begin
                    if (any_key) begin
                        state_d = ST_HELD;
                        fire    = one_key;
                    end
                end
                ST_HELD: begin
                    if (!any_key) begin
                        state_d = ST_IDLE;
                    end else if (repeat_due) begin
                        fire = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int REP_W = $clog2(REPEAT_FRAMES + 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_FRAMES - 1);

    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             chg_q, chg_d;

    assign repeat_due = (state_q == ST_HELD) && one_key && !chg_q && (rep_cnt_q == REP_LAST);

    // Count frames while one key stays held; restart on any change of the stable frame
    always_comb begin
        chg_d     = upd_d && (stable_d != stable_q);
        rep_cnt_d = rep_cnt_q;
        if (upd_q) begin
            if (state_q == ST_HELD && state_d == ST_HELD && one_key && !chg_q) begin
                rep_cnt_d = (rep_cnt_q == REP_LAST) ? '0 : rep_cnt_q + 1'b1;
            end else begin
                rep_cnt_d = '0;
            end
        end
    end

    // Auto-repeat state registers
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            rep_cnt_q <= '0;
            chg_q     <= 1'b0;
        end else begin
            rep_cnt_q <= rep_cnt_d;
            chg_q     <= chg_d;
        end
    end
`else
    assign repeat_due = 1'b0;
`endif

    // Output event: latch the code and shift it into the four-digit history
    always_comb begin
        key_code_d  = fire ? key_idx : key_code_q;
        key_valid_d = fire;
        data_d      = fire ? {data_q[11:0], key_idx} : data_q;
        key_down_d  = any_key;
    end

    // All scanner state registers
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            row_meta_q  <= 4'hF;
            row_sync_q  <= 4'hF;
            scan_cnt_q  <= '0;
            col_q       <= 2'd0;
            raw_q       <= '0;
            prev_q      <= '0;
            stable_q    <= '0;
            match_q     <= '0;
            upd_q       <= 1'b0;
            state_q     <= ST_IDLE;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            key_down_q  <= 1'b0;
            data_q      <= 16'h0000;
        end else begin
            row_meta_q  <= row_meta_d;
            row_sync_q  <= row_sync_d;
            scan_cnt_q  <= scan_cnt_d;
            col_q       <= col_d;
            raw_q       <= raw_d;
            prev_q      <= prev_d;
            stable_q    <= stable_d;
            match_q     <= match_d;
            upd_q       <= upd_d;
            state_q     <= state_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_down_q  <= key_down_d;
            data_q      <= data_d;
        end
    end

    assign kp.KEY_COL   = ~(4'b0001 << col_q);
    assign kp.key_code  = key_code_q;
    assign kp.key_valid = key_valid_q;
    assign kp.key_down  = key_down_q;
    assign kp.data      = data_q;
endmodule

// File: tb/tb_keypad_scan_4x4.sv
// tb_keypad_scan_4x4: frame-synchronous random keypad stimulus with a
// frame-level reference model feeding an event scoreboard.
module tb_keypad_scan_4x4;
    localparam int SCAN_DIV     = 4;
    localparam int DEBOUNCE_CNT = 3;
    localparam int FRAME        = 4 * SCAN_DIV;

    typedef struct {
        logic [3:0]  code;
        logic [15:0] data;
        int          cyc;
    } exp_event_t;

    logic        CLK  = 1'b0;
    logic        RSTN = 1'b0;
    logic [15:0] keys = 16'h0000;
    logic [3:0]  row_val;
    int          cyc;
    int          errors = 0;
    int          checks = 0;
    int          valid_count = 0;
    exp_event_t  exp_q[$];
    exp_event_t  mon_e;
    logic [3:0]  mon_col;

    logic [15:0] m_prev;
    logic [15:0] m_stable;
    logic [15:0] m_data;
    int          m_match;
    bit          m_held;

    keypad_scan_4x4_if kp_if();

    keypad_scan_4x4 #(
        .SCAN_DIV(SCAN_DIV),
        .DEBOUNCE_CNT(DEBOUNCE_CNT),
        .REPEAT_FRAMES(4)
    ) dut (
        .CLK(CLK),
        .RSTN(RSTN),
        .kp(kp_if)
    );

    always #5 CLK = ~CLK;

    // Physical key matrix: a pressed key pulls its row low while its column is driven
    always_comb begin
        row_val = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!kp_if.KEY_COL[c] && keys[r*4+c]) begin
                    row_val[r] = 1'b0;
                end
            end
        end
    end
    assign kp_if.KEY_ROW = row_val;

    // Bench timebase: cycles since the last reset release
    always @(posedge CLK or negedge RSTN) begin
        if (!RSTN) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h at cycle %0d", name, actual, expected, cyc);
        end
    endtask

    task automatic waitCycle(input int target);
        int guard;
        guard = 0;
        while (cyc != target && guard < 4 * FRAME) begin
            @(negedge CLK);
            guard++;
        end
        if (cyc != target) begin
            checks++;
            errors++;
            $display("[TB] FAIL wait_timeout: reached cycle %0d, required %0d", cyc, target);
        end
    endtask

    task automatic modelReset();
        m_prev   = 16'h0;
        m_stable = 16'h0;
        m_data   = 16'h0;
        m_match  = 0;
        m_held   = 1'b0;
    endtask

    // Frame-level reference: debounce on whole frames, lone key from idle makes an event
    task automatic modelFrame(input logic [15:0] mask, input int end_cyc);
        logic [3:0] idx;
        if (mask == m_prev) begin
            if (m_match < DEBOUNCE_CNT) m_match++;
        end else begin
            m_match = 1;
        end
        m_prev = mask;
        if (m_match >= DEBOUNCE_CNT) begin
            m_stable = mask;
            if (!m_held) begin
                if ($countones(mask) == 1) begin
                    idx    = 4'($clog2(mask));
                    m_data = {m_data[11:0], idx};
                    exp_q.push_back('{code: idx, data: m_data, cyc: end_cyc});
                    m_held = 1'b1;
                end else if (mask != 16'h0) begin
                    m_held = 1'b1;
                end
            end else if (mask == 16'h0) begin
                m_held = 1'b0;
            end
        end
    endtask

    // Hold a key mask for whole frames, starting at a frame boundary
    task automatic applyStimulus(input logic [15:0] mask, input int frames);
        int base;
        for (int f = 0; f < frames; f++) begin
            base = cyc;
            keys = mask;
            waitCycle(base + FRAME / 2);
            checkOutput("key_down", {31'b0, kp_if.key_down}, {31'b0, (m_stable != 16'h0)});
            waitCycle(base + FRAME - 1);
            modelFrame(mask, base + FRAME - 1);
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_key_col"},   {28'b0, kp_if.KEY_COL},  32'hE);
        checkOutput({tag, "_key_code"},  {28'b0, kp_if.key_code}, 32'h0);
        checkOutput({tag, "_key_valid"}, {31'b0, kp_if.key_valid}, 32'h0);
        checkOutput({tag, "_key_down"},  {31'b0, kp_if.key_down}, 32'h0);
        checkOutput({tag, "_data"},      {16'b0, kp_if.data},     32'h0);
    endtask

    // Monitor: column strobe sequence every cycle, scoreboard pop on each key event
    always @(negedge CLK) begin
        if (RSTN) begin
            mon_col = 4'b0001 << ((cyc / SCAN_DIV) % 4);
            mon_col = ~mon_col;
            checkOutput("key_col", {28'b0, kp_if.KEY_COL}, {28'b0, mon_col});
            if (kp_if.key_valid) begin
                valid_count++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_event: got code 0x%0h data 0x%0h, required no event at cycle %0d",
                             kp_if.key_code, kp_if.data, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    checkOutput("event_code", {28'b0, kp_if.key_code}, {28'b0, mon_e.code});
                    checkOutput("event_data", {16'b0, kp_if.data}, {16'b0, mon_e.data});
                    checkOutput("event_latency", {31'b0, (cyc > mon_e.cyc) && (cyc - mon_e.cyc <= FRAME)}, 32'h1);
                end
            end
        end
    end

    // Main sequence
    initial begin
        int start_count;
        int kind;
        int nb;
        logic [15:0] m;
        logic [3:0] seq_codes [4];

        modelReset();
        repeat (3) @(negedge CLK);
        checkResetState("reset");
        RSTN = 1'b1;

        // Idle scanning with no keys
        applyStimulus(16'h0000, 4);
        checkOutput("idle_valid_count", valid_count, 0);
        checkOutput("idle_data", {16'b0, kp_if.data}, 32'h0);

        // Clean press of row1/col2 then release
        applyStimulus(16'h0040, 5);
        checkOutput("k6_valid_count", valid_count, 1);
        checkOutput("k6_code", {28'b0, kp_if.key_code}, 32'h6);
        checkOutput("k6_data", {16'b0, kp_if.data}, 32'h0006);
        checkOutput("k6_key_down", {31'b0, kp_if.key_down}, 32'h1);
        applyStimulus(16'h0000, 4);
        checkOutput("k6_release_down", {31'b0, kp_if.key_down}, 32'h0);

        // Press 1, 2, A, F then 3
        seq_codes[0] = 4'h1;
        seq_codes[1] = 4'h2;
        seq_codes[2] = 4'hA;
        seq_codes[3] = 4'hF;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(16'h0001 << seq_codes[i], 4);
            if (i == 3) checkOutput("seq_data_4", {16'b0, kp_if.data}, 32'h12AF);
            applyStimulus(16'h0000, 4);
        end
        applyStimulus(16'h0008, 4);
        checkOutput("seq_data_5", {16'b0, kp_if.data}, 32'h2AF3);
        applyStimulus(16'h0000, 4);

        // Key bouncing every frame never settles
        start_count = valid_count;
        for (int i = 0; i < 20; i++) begin
            applyStimulus((i % 2 == 0) ? 16'h0040 : 16'h0000, 1);
        end
        applyStimulus(16'h0000, 4);
        checkOutput("bounce_no_event", valid_count - start_count, 0);

        // Two keys together, then one released, then full release and a fresh press
        start_count = valid_count;
        applyStimulus(16'h0801, 5);
        checkOutput("pair_no_event", valid_count - start_count, 0);
        applyStimulus(16'h0001, 5);
        checkOutput("partial_release_no_event", valid_count - start_count, 0);
        applyStimulus(16'h0000, 4);
        applyStimulus(16'h0001, 4);
        checkOutput("after_release_event", valid_count - start_count, 1);
        checkOutput("after_release_code", {28'b0, kp_if.key_code}, 32'h0);
        applyStimulus(16'h0000, 4);

        // Randomized presses, bounces, chords and short taps
        for (int n = 0; n < 30; n++) begin
            kind = $urandom_range(0, 3);
            m    = 16'h0001 << $urandom_range(0, 15);
            case (kind)
                0: applyStimulus(m, $urandom_range(3, 6));
                1: begin
                    nb = $urandom_range(2, 5);
                    for (int b = 0; b < nb; b++) begin
                        applyStimulus((b % 2 == 0) ? m : 16'h0000, 1);
                    end
                    applyStimulus(m, 4);
                end
                2: applyStimulus(m | (16'h0001 << $urandom_range(0, 15)), $urandom_range(3, 5));
                default: applyStimulus(m, $urandom_range(1, 2));
            endcase
            applyStimulus(16'h0000, $urandom_range(1, 4));
        end
        applyStimulus(16'h0000, 4);

        // Reset for two cycles mid-dwell while key 5 is held
        applyStimulus(16'h0020, 5);
        waitCycle(cyc + 6);
        checkOutput("pending_before_reset", exp_q.size(), 0);
        exp_q.delete();
        RSTN = 1'b0;
        modelReset();
        start_count = valid_count;
        @(negedge CLK);
        checkResetState("midreset");
        @(negedge CLK);
        RSTN = 1'b1;
        applyStimulus(16'h0020, 5);
        checkOutput("post_reset_event", valid_count - start_count, 1);
        checkOutput("post_reset_code", {28'b0, kp_if.key_code}, 32'h5);
        checkOutput("post_reset_data", {16'b0, kp_if.data}, 32'h0005);
        applyStimulus(16'h0000, 4);

        checkOutput("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Guard against a stalled run
    initial begin
        #2000000;
        $display("[TB] FAIL timeout: simulation did not complete, required completion before 2000000");
        $fatal(1, "[TB] timeout");
    end
endmodule
